qep_decoder_ctrl: RTL and testbench
===================================

Name: qep_decoder_ctrl

Overview:
- Quadrature decode controller placed after the per-channel QEP debounce/qualification stages.
- Takes qualified A, B and index levels. Sequences a 4x decode state machine, maintains a wrapping position counter, latches position on index, measures the edge-to-edge period and flags illegal transitions.
- Output feeds the drive's speed/position loop through a register interface.

Parameters:
- CNT_W, 32, width of position, max_count, index_pos.
- PER_W, 24, width of the edge-period counter and edge_period output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  decode enable; when 0, position and period are frozen and no errors are flagged.
- qep_a  input  1  qualified channel A (already synchronised and debounced).
- qep_b  input  1  qualified channel B.
- qep_i  input  1  qualified index.
- max_count  input  CNT_W  position wrap limit (inclusive).
- err_clr  input  1  single-cycle clear of the sticky error.
- position  output  CNT_W  current position count.
- direction  output  1  1 = forward, 0 = reverse; last valid step.
- index_pos  output  CNT_W  position captured at the last index rising edge.
- index_flag  output  1  one-cycle pulse on index rising edge.
- edge_period  output  PER_W  clk cycles between the last two valid edges.
- step  output  1  one-cycle pulse per valid count step.
- qep_err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset values:
  - position=0, direction=0, index_pos=0, index_flag=0, edge_period=0, step=0, qep_err=0.
  - Internal prev_ab=00, prev_i=0, period counter=0, FSM=INIT.
- FSM INIT:
  - First clk after reset release: load prev_ab={qep_a,qep_b} and prev_i=qep_i.
  - No count, no error. Go to RUN.
- FSM RUN, each clk with enable=1, compare cur={qep_a,qep_b} to prev_ab:
  - Equal: no step; period counter +1, saturating at all-ones.
  - Forward sequence 00->01->11->10->00: position +1, direction=1, step=1.
  - Reverse sequence: position -1, direction=0, step=1.
  - Both bits changed: qep_err=1, no count, direction held, step=0.
  - prev_ab<=cur every RUN cycle, including the error case.
- Latency:
  - position, direction, step and edge_period update on the same edge that first sees the changed input.
  - New values are visible one clk after the input change is sampled.
- Period measurement:
  - On a valid step: edge_period<=counter+1, saturating; counter<=0.
  - Error cycles neither capture nor reset the counter.
- Wrap rules:
  - Increment at position==max_count gives 0.
  - Decrement at position==0 gives max_count.
  - If position>max_count (max_count lowered at runtime), the next step loads 0 regardless of direction.
  - max_count=0: position stays 0; step still pulses.
- Index handling:
  - Rising edge (qep_i=1, prev_i=0) gives index_flag=1 for 1 clk.
  - index_pos<=position value after this cycle's step.
- enable=0:
  - prev_ab and prev_i keep tracking inputs, so there is no spurious step or error on re-enable.
  - Counter, position, index and error logic are held.
  - step=0, index_flag=0.
- err_clr:
  - Clears qep_err.
  - If an illegal transition occurs in the same cycle, set wins and qep_err=1.
- Reset mid-operation: all state returns to reset values immediately; the FSM restarts in INIT.

Optional Feature:
- Macro QEP_INDEX_RESET_EN.
- Defined: an index rising edge also loads position<=0. This overrides any simultaneous step; step and direction still update. index_pos captures the pre-clear post-step value.
- Undefined: the index only captures and pulses; position is unaffected.

Test Plan:
- Reset with a=b=1, then release: step=0, qep_err=0, position=0 (INIT absorbs the initial state).
- max_count=3, forward sequence 00,01,11,10,00,01 held 5 clk each: position 1,2,3,0,1; direction=1; edge_period=5 after the second step.
- From position=0, reverse step 00->10: position=3, direction=0, step pulse of 1 clk.
- 00->11 in one cycle: qep_err=1, position unchanged. err_clr the next cycle gives qep_err=0. err_clr coincident with another 00->11 keeps qep_err=1.
- Index rising edge coincident with a forward step at position=5, max_count=100:
  - index_pos=6, index_flag 1 clk.
  - With QEP_INDEX_RESET_EN: position=0. Without it: position=6.
- position=50, max_count changed to 10, then one reverse step: position=0. Hold inputs >2^24 clk: edge_period captures 0xFFFFFF on the next step.

Source files
------------

// File: rtl/qep_decoder_ctrl.sv
// qep_decoder_ctrl
// Quadrature (4x) decode controller that follows the QEP qualification stages.
// It takes qualified A/B/index levels, keeps a wrapping position count, latches
// the position on each index rising edge, measures clk cycles between valid
// edges and flags illegal (both-bits-changed) transitions with a sticky error.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       decode enable; 0 freezes position/period/index/error logic
//   qep_a/qep_b  qualified quadrature channels
//   qep_i        qualified index
//   max_count    inclusive position wrap limit
//   err_clr      single-cycle clear of qep_err (a coincident error wins)
//   position     current position count
//   direction    1 = forward, 0 = reverse (last valid step)
//   index_pos    position captured at the last index rising edge
//   index_flag   one-cycle pulse on index rising edge
//   edge_period  clk cycles between the last two valid edges (saturating)
//   step         one-cycle pulse per valid count step
//   qep_err      sticky illegal-transition flag
//
// Build option: define QEP_INDEX_RESET_EN to make an index rising edge also
// clear the position (index_pos still captures the pre-clear value).

module qep_decoder_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PER_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             qep_a,
  input  logic             qep_b,
  input  logic             qep_i,
  input  logic [CNT_W-1:0] max_count,
  input  logic             err_clr,
  output logic [CNT_W-1:0] position,
  output logic             direction,
  output logic [CNT_W-1:0] index_pos,
  output logic             index_flag,
  output logic [PER_W-1:0] edge_period,
  output logic             step,
  output logic             qep_err
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [1:0]       r_prev_ab;
  logic             r_prev_i;
  logic [PER_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_position;
  logic             r_direction;
  logic [CNT_W-1:0] r_index_pos;
  logic             r_index_flag;
  logic [PER_W-1:0] r_edge_period;
  logic             r_step;
  logic             r_err;

  logic [1:0]       w_cur_ab;
  logic [1:0]       w_delta;
  logic             w_run;
  logic             w_fwd;
  logic             w_rev;
  logic             w_ill;
  logic             w_same;
  logic             w_idx_rise;
  logic [CNT_W-1:0] w_pos_step;
  logic [PER_W-1:0] w_per_inc;

  // Gray code 00,01,11,10 mapped to phase 0..3 so a step is a +/-1 phase delta.
  function automatic logic [1:0] ab_phase(input logic [1:0] ab);
    logic [1:0] ph;
    ph = {ab[1], ab[1] ^ ab[0]};
    return ph;
  endfunction

  assign w_cur_ab = {qep_a, qep_b};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: INIT only absorbs the input levels seen after reset.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:  w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StInit;
    endcase
  end

  // Decode and datapath next values
  always_comb begin
    w_run      = (r_state == StRun) && enable;
    w_delta    = ab_phase(w_cur_ab) - ab_phase(r_prev_ab);
    w_same     = w_run && (w_delta == 2'd0);
    w_fwd      = w_run && (w_delta == 2'd1);
    w_ill      = w_run && (w_delta == 2'd2);
    w_rev      = w_run && (w_delta == 2'd3);
    w_idx_rise = w_run && qep_i && !r_prev_i;

    w_per_inc = (r_per_cnt == {PER_W{1'b1}}) ? r_per_cnt : r_per_cnt + 1'b1;

    // Position after this cycle's step (before any index clear).
    w_pos_step = r_position;
    if (w_fwd || w_rev) begin
      if (r_position > max_count) begin
        // max_count was lowered below the current count: resync to zero.
        w_pos_step = '0;
      end else if (w_fwd) begin
        w_pos_step = (r_position == max_count) ? '0 : r_position + 1'b1;
      end else begin
        w_pos_step = (r_position == '0) ? max_count : r_position - 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_ab     <= 2'b00;
      r_prev_i      <= 1'b0;
      r_per_cnt     <= '0;
      r_position    <= '0;
      r_direction   <= 1'b0;
      r_index_pos   <= '0;
      r_index_flag  <= 1'b0;
      r_edge_period <= '0;
      r_step        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // Track inputs in every state so re-enable never sees a stale edge.
      r_prev_ab    <= w_cur_ab;
      r_prev_i     <= qep_i;
      r_step       <= w_fwd || w_rev;
      r_index_flag <= w_idx_rise;

      if (w_same) begin
        r_per_cnt <= w_per_inc;
      end else if (w_fwd || w_rev) begin
        r_per_cnt     <= '0;
        r_edge_period <= w_per_inc;
        r_direction   <= w_fwd;
      end

`ifdef QEP_INDEX_RESET_EN
      r_position <= w_idx_rise ? '0 : w_pos_step;
`else
      r_position <= w_pos_step;
`endif

      if (w_idx_rise) begin
        r_index_pos <= w_pos_step;
      end

      if (w_ill) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign position    = r_position;
  assign direction   = r_direction;
  assign index_pos   = r_index_pos;
  assign index_flag  = r_index_flag;
  assign edge_period = r_edge_period;
  assign step        = r_step;
  assign qep_err     = r_err;

endmodule

// File: tb/tb_qep_decoder_ctrl.sv
// Directed bench for qep_decoder_ctrl. A narrow period counter (PER_W = 10) keeps
// the saturation check short.

module tb_qep_decoder_ctrl;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PER_W = 10;
  localparam logic [PER_W-1:0] PerSat = {PER_W{1'b1}};

`ifdef QEP_INDEX_RESET_EN
  localparam logic [CNT_W-1:0] IdxPos = 32'd0;
`else
  localparam logic [CNT_W-1:0] IdxPos = 32'd6;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             qep_a;
  logic             qep_b;
  logic             qep_i;
  logic [CNT_W-1:0] max_count;
  logic             err_clr;
  logic [CNT_W-1:0] position;
  logic             direction;
  logic [CNT_W-1:0] index_pos;
  logic             index_flag;
  logic [PER_W-1:0] edge_period;
  logic             step;
  logic             qep_err;

  int n_tests = 0;
  int n_fail  = 0;

  qep_decoder_ctrl #(
    .CNT_W(CNT_W),
    .PER_W(PER_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .qep_a      (qep_a),
    .qep_b      (qep_b),
    .qep_i      (qep_i),
    .max_count  (max_count),
    .err_clr    (err_clr),
    .position   (position),
    .direction  (direction),
    .index_pos  (index_pos),
    .index_flag (index_flag),
    .edge_period(edge_period),
    .step       (step),
    .qep_err    (qep_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       ab;
    logic             i;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] max;
    int               hold;
    logic [CNT_W-1:0] pos;
    logic             dir;
    logic             stp;
    logic             err;
    logic             flag;
    logic [CNT_W-1:0] ipos;
    logic             chk_per;
    logic [PER_W-1:0] per;
  } vec_t;

  vec_t vecs[$];

  // Gray sequence in forward order; ph indexes the current A/B state.
  logic [1:0] gray [4];
  int         ph;

  function automatic vec_t mk(input logic [1:0] ab, input logic i, input logic en,
                              input logic clr, input logic [CNT_W-1:0] max, input int hold,
                              input logic [CNT_W-1:0] pos, input logic dir, input logic stp,
                              input logic err, input logic flag, input logic [CNT_W-1:0] ipos,
                              input logic chk_per, input logic [PER_W-1:0] per);
    vec_t v;
    v.ab = ab; v.i = i; v.en = en; v.clr = clr; v.max = max; v.hold = hold;
    v.pos = pos; v.dir = dir; v.stp = stp; v.err = err; v.flag = flag; v.ipos = ipos;
    v.chk_per = chk_per; v.per = per;
    return v;
  endfunction

  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    qep_a = ab[1];
    qep_b = ab[0];
  endtask

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;

    // ab, i, en, clr, max, hold | pos, dir, step, err, flag, ipos, chk_per, per
    vecs.push_back(mk(2'b01, 0, 1, 0,   3, 5, 1,      1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 0, 1, 0,   3, 5, 2,      1, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b10, 0, 1, 0,   3, 5, 3,      1, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b00, 0, 1, 0,   3, 5, 0,      1, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b01, 0, 1, 0,   3, 5, 1,      1, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b00, 0, 1, 0,   3, 1, 0,      0, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b10, 0, 1, 0,   3, 2, 3,      0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(2'b10, 0, 1, 0,   3, 1, 3,      0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(2'b01, 0, 1, 0,   3, 1, 3,      0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(2'b01, 0, 1, 1,   3, 1, 3,      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 1, 1,   3, 1, 3,      0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 1, 1,   3, 1, 3,      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 1, 0,   3, 1, 0,      1, 1, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b01, 0, 0, 0,   3, 1, 0,      1, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b01, 0, 1, 0,   3, 1, 0,      1, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(2'b11, 0, 1, 0, 100, 1, 1,      1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 0, 1, 0, 100, 1, 2,      1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(2'b00, 0, 1, 0, 100, 1, 3,      1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(2'b01, 0, 1, 0, 100, 1, 4,      1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(2'b11, 0, 1, 0, 100, 1, 5,      1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(2'b10, 1, 1, 0, 100, 1, IdxPos, 1, 1, 0, 1, 6, 1, 1));
    vecs.push_back(mk(2'b10, 1, 1, 0, 100, 1, IdxPos, 1, 0, 0, 0, 6, 1, 1));

    // Reset with a=b=1; INIT must absorb the level without a step or error.
    reset = 1'b1; enable = 1'b1; qep_i = 1'b0; err_clr = 1'b0; max_count = 32'd3;
    drive_ab(2'b11);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
    check("rst_pos", position, 0);
    check("rst_dir", {31'd0, direction}, 0);
    check("rst_step", {31'd0, step}, 0);
    check("rst_err", {31'd0, qep_err}, 0);
    check("rst_flag", {31'd0, index_flag}, 0);
    check("rst_ipos", index_pos, 0);
    check("rst_per", {22'd0, edge_period}, 0);

    // Move A/B to 00 while disabled: no step or error may result.
    enable = 1'b0;
    drive_ab(2'b00);
    tick();
    check("dis_step", {31'd0, step}, 0);
    check("dis_err", {31'd0, qep_err}, 0);
    enable = 1'b1;
    tick();
    check("reen_err", {31'd0, qep_err}, 0);

    foreach (vecs[k]) begin
      drive_ab(vecs[k].ab);
      qep_i     = vecs[k].i;
      enable    = vecs[k].en;
      err_clr   = vecs[k].clr;
      max_count = vecs[k].max;
      tick();
      check($sformatf("v%0d_pos", k), position, vecs[k].pos);
      check($sformatf("v%0d_dir", k), {31'd0, direction}, {31'd0, vecs[k].dir});
      check($sformatf("v%0d_step", k), {31'd0, step}, {31'd0, vecs[k].stp});
      check($sformatf("v%0d_err", k), {31'd0, qep_err}, {31'd0, vecs[k].err});
      check($sformatf("v%0d_flag", k), {31'd0, index_flag}, {31'd0, vecs[k].flag});
      check($sformatf("v%0d_ipos", k), index_pos, vecs[k].ipos);
      if (vecs[k].chk_per) begin
        check($sformatf("v%0d_per", k), {22'd0, edge_period}, {22'd0, vecs[k].per});
      end
      err_clr = 1'b0;
      for (int h = 1; h < vecs[k].hold; h++) tick();
    end

    // Walk forward up to position 50 (A/B currently 10, phase 3).
    ph = 3;
    qep_i = 1'b0;
    for (int p = int'(IdxPos); p < 50; p++) begin
      ph = (ph + 1) % 4;
      drive_ab(gray[ph]);
      tick();
    end
    check("walk_pos50", position, 50);

    // Lower max_count below position; next step (reverse) must resync to 0.
    max_count = 32'd10;
    ph = (ph + 3) % 4;
    drive_ab(gray[ph]);
    tick();
    check("lower_max_pos", position, 0);
    check("lower_max_dir", {31'd0, direction}, 0);
    check("lower_max_step", {31'd0, step}, 1);
    tick();
    check("lower_max_step_end", {31'd0, step}, 0);

    // Long hold saturates the period counter; next step captures all-ones.
    repeat (1100) tick();
    ph = (ph + 1) % 4;
    drive_ab(gray[ph]);
    tick();
    check("sat_per", {22'd0, edge_period}, {22'd0, PerSat});
    check("sat_pos", position, 1);
    check("sat_dir", {31'd0, direction}, 1);

    // Create an error, then reset mid-operation: state clears immediately.
    ph = (ph + 2) % 4;
    drive_ab(gray[ph]);
    tick();
    check("pre_rst_err", {31'd0, qep_err}, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_pos", position, 0);
    check("mid_rst_err", {31'd0, qep_err}, 0);
    check("mid_rst_dir", {31'd0, direction}, 0);
    check("mid_rst_ipos", index_pos, 0);
    check("mid_rst_per", {22'd0, edge_period}, 0);
    // Release with A/B = 11 (two bits away from the reset prev_ab of 00).
    drive_ab(2'b11);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("reinit_err", {31'd0, qep_err}, 0);
    check("reinit_step", {31'd0, step}, 0);
    check("reinit_pos", position, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
